// File: rtl/led_sequencer.sv
// One-hot LED chaser: four selectable patterns, run-time dwell in ticks, pause control.
// Latency: pos/led/wrap are registered and change on the clock edge that takes the step.
// Backpressure: none; enable=0 freezes every counter and the lit LED in place.
module led_sequencer #(
  parameter int NUM_LEDS = 8,
  parameter int CLK_HZ   = 10000000,
  parameter int TICK_HZ  = 1000,
  parameter int DWELL_W  = 16,
  parameter int POS_W    = $clog2(NUM_LEDS)
) (
  input  logic                clk,
  input  logic                rstn,
  input  logic [1:0]          mode,
  input  logic [DWELL_W-1:0]  dwell_ms,
  input  logic                enable,
  output logic [NUM_LEDS-1:0] led,
  output logic [POS_W-1:0]    pos,
  output logic                wrap
);

  // Prescaler divides clk down to the dwell time base.
  localparam int DIV     = CLK_HZ / TICK_HZ;
  localparam int PRESC_W = (DIV > 1) ? $clog2(DIV) : 1;

  localparam logic [PRESC_W-1:0] PRESC_MAX = PRESC_W'(DIV - 1);
  localparam logic [POS_W-1:0]   POS_LAST  = POS_W'(NUM_LEDS - 1);
  localparam logic [POS_W-1:0]   POS_PEN   = POS_W'(NUM_LEDS - 2);
  localparam logic [POS_W-1:0]   POS_ONE   = POS_W'(1);
  localparam logic [POS_W-1:0]   POS_TWO   = POS_W'(2);

  localparam logic [1:0] MODE_ASC = 2'd0;
  localparam logic [1:0] MODE_ILV = 2'd1;
  localparam logic [1:0] MODE_DSC = 2'd2;
  localparam logic [1:0] MODE_PP  = 2'd3;

  // Ping-pong direction; only meaningful in MODE_PP.
  localparam logic DIR_UP   = 1'b0;
  localparam logic DIR_DOWN = 1'b1;

  logic [PRESC_W-1:0]  presc_q, presc_d;
  logic [DWELL_W-1:0]  dwell_cnt_q, dwell_cnt_d;
  logic [POS_W-1:0]    pos_q, pos_d;
  logic [NUM_LEDS-1:0] led_q, led_d;
  logic                dir_q, dir_d;
  logic                wrap_q, wrap_d;

  logic                tick;
  logic                step;
  logic [DWELL_W-1:0]  dwell_lim;
  logic [POS_W-1:0]    pos_nxt;
  logic                dir_nxt;

  // Tick on the prescaler terminal count; step once the dwell has been served.
  // The >= compare lets a lowered dwell_ms take effect at the very next tick.
  always_comb begin
    dwell_lim = (dwell_ms == '0) ? '0 : dwell_ms - DWELL_W'(1);
    tick      = enable && (presc_q == PRESC_MAX);
    step      = tick && (dwell_cnt_q >= dwell_lim);
  end

  // Next LED index from the current position under the currently selected mode.
  always_comb begin
    pos_nxt = pos_q;
    dir_nxt = DIR_UP;
    case (mode)
      MODE_ASC: begin
        pos_nxt = (pos_q == POS_LAST) ? '0 : pos_q + POS_ONE;
      end
      MODE_ILV: begin
        if (pos_q == POS_LAST) begin
          pos_nxt = '0;
        end else if (pos_q == POS_PEN) begin
          pos_nxt = POS_ONE;
        end else begin
          pos_nxt = pos_q + POS_TWO;
        end
      end
      MODE_DSC: begin
        pos_nxt = (pos_q == '0) ? POS_LAST : pos_q - POS_ONE;
      end
      MODE_PP: begin
        if (dir_q == DIR_UP) begin
          if (pos_q == POS_LAST) begin
            pos_nxt = POS_PEN;
            dir_nxt = DIR_DOWN;
          end else begin
            pos_nxt = pos_q + POS_ONE;
            dir_nxt = DIR_UP;
          end
        end else begin
          if (pos_q == '0) begin
            pos_nxt = POS_ONE;
            dir_nxt = DIR_UP;
          end else begin
            pos_nxt = pos_q - POS_ONE;
            dir_nxt = DIR_DOWN;
          end
        end
      end
      default: begin
        pos_nxt = pos_q;
        dir_nxt = DIR_UP;
      end
    endcase
  end

  // Advance prescaler and dwell counter while enabled; take the step when due.
  always_comb begin
    presc_d     = presc_q;
    dwell_cnt_d = dwell_cnt_q;
    pos_d       = pos_q;
    led_d       = led_q;
    dir_d       = dir_q;
    wrap_d      = 1'b0;
    if (enable) begin
      presc_d = tick ? '0 : presc_q + PRESC_W'(1);
      if (step) begin
        dwell_cnt_d = '0;
        pos_d       = pos_nxt;
        led_d       = NUM_LEDS'(1) << pos_nxt;
        dir_d       = dir_nxt;
        wrap_d      = (pos_nxt == '0);
      end else if (tick) begin
        dwell_cnt_d = dwell_cnt_q + DWELL_W'(1);
      end
    end
  end

  // State registers; reset lights LED0 and clears all counters.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      presc_q     <= '0;
      dwell_cnt_q <= '0;
      pos_q       <= '0;
      led_q       <= NUM_LEDS'(1);
      dir_q       <= DIR_UP;
      wrap_q      <= 1'b0;
    end else begin
      presc_q     <= presc_d;
      dwell_cnt_q <= dwell_cnt_d;
      pos_q       <= pos_d;
      led_q       <= led_d;
      dir_q       <= dir_d;
      wrap_q      <= wrap_d;
    end
  end

  assign led  = led_q;
  assign pos  = pos_q;
  assign wrap = wrap_q;

endmodule
